dil_stream_sequencer: RTL and testbench

- Synthesizable, table-driven stream sequencer that exercises the `dilithium` core's valid/ready word interface for any mode (keygen/sign/verify), security level or performance variant.
- Replaces hard-coded per-mode load/unload orderings with a programmable segment table. Each segment is an input or output transfer of N words at a base address in a shared vector memory.
- Drives the DUT reset and start, compares unloaded words against expected data, and records per-segment and total cycle counts.
- Sits between a host/vector RAM and the DUT, for on-FPGA benchmarking and for simulation benches.

---
 rtl/dil_seq_pkg.sv | 18 +
 rtl/dil_seq_prefetch.sv | 65 ++++++
 rtl/dil_stream_sequencer.sv | 148 ++++++++++++++
 tb/tb_dil_stream_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dil_seq_pkg.sv
// dil_seq_pkg: shared types and constants for the dilithium stream sequencer.
package dil_seq_pkg;
    localparam int SEQ_LEN_W = 12;
    typedef enum logic [2:0] {S_IDLE, S_DRST, S_START, S_SEG, S_LOAD, S_UNLOAD, S_DONE} seq_state_t;
    typedef struct packed {
        logic                 dir;
        logic [SEQ_LEN_W-1:0] len;
        logic [SEQ_LEN_W-1:0] base;
    } seg_desc_t;
    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/dil_seq_prefetch.sv
// dil_seq_prefetch: RAM address generator feeding a 2-entry skid FIFO, with the
// in-flight RAM word bypassed to the head so the 1-cycle read latency is hidden.
module dil_seq_prefetch #(
    parameter int W     = 64,
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] base_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             pop_i,
    output logic [LEN_W-1:0] mem_addr_o,
    input  logic [W-1:0]     mem_rdata_i,
    output logic             valid_o,
    output logic [W-1:0]     data_o
);
    logic [LEN_W-1:0] addr_q, addr_d, rem_q, rem_d;
    logic             pend_q, pend_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [W-1:0]     buf_q [2];
    logic             issue, push, pop_buf;
    logic [2:0]       after_pop;

    assign valid_o    = cnt_q != 2'd0 || pend_q;
    assign data_o     = cnt_q != 2'd0 ? buf_q[0] : mem_rdata_i;
    assign mem_addr_o = start_i ? base_i : addr_q;
    assign pop_buf    = pop_i && cnt_q != 2'd0;
    assign push       = pend_q && !(pop_i && cnt_q == 2'd0);
    // Only request another word if it is guaranteed a free slot when it lands.
    assign after_pop  = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop_i};
    assign issue      = rem_q != '0 && after_pop <= 3'd1;

    always_comb begin
        addr_d = start_i ? base_i + LEN_W'(1) : issue ? addr_q + LEN_W'(1) : addr_q;
        rem_d  = start_i ? len_i - LEN_W'(1) : issue ? rem_q - LEN_W'(1) : rem_q;
        pend_d = start_i || issue;
        cnt_d  = cnt_q + 2'(push) - 2'(pop_buf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pop_buf) buf_q[0] <= buf_q[1];
        if (push) buf_q[cnt_q[0] ^ pop_buf] <= mem_rdata_i;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk)
        if (!rst && start_i && {1'b0, base_i} + {1'b0, len_i} > {1'b1, {LEN_W{1'b0}}})
            $warning("dil_seq_prefetch: segment at base %0d len %0d wraps the address space", base_i, len_i);
`endif
endmodule

// File: rtl/dil_stream_sequencer.sv
// dil_stream_sequencer: table-driven load/unload sequencer for the dilithium word interface.
// Define DIL_STREAM_SEQ_STALL_EN to gate handshakes with a pseudo-random LFSR stall.
module dil_stream_sequencer
    import dil_seq_pkg::*;
#(
    parameter int W          = 64,
    parameter int MAX_SEGS   = 16,
    parameter int LEN_W      = SEQ_LEN_W,
    parameter int CYC_W      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        seg_we,
    input  logic [$clog2(MAX_SEGS)-1:0] seg_waddr,
    input  logic [2*LEN_W:0]            seg_wdata,
    input  logic [$clog2(MAX_SEGS):0]   num_segs,
    input  logic                        go,
    output logic [LEN_W-1:0]            mem_addr,
    input  logic [W-1:0]                mem_rdata,
    output logic                        dut_rst,
    output logic                        dut_start,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [W-1:0]                m_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [W-1:0]                s_data,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [LEN_W-1:0]            err_cnt,
    input  logic [$clog2(MAX_SEGS)-1:0] cyc_raddr,
    output logic [CYC_W-1:0]            cyc_rdata,
    output logic [CYC_W-1:0]            total_cyc
);
    localparam int IW = $clog2(MAX_SEGS);
    localparam int RW = $clog2(RST_CYCLES + 1);

    seq_state_t       state_q, state_d;
    seg_desc_t        tbl_q [MAX_SEGS];
    logic [CYC_W-1:0] cyc_q [MAX_SEGS];
    seg_desc_t        entry;
    logic [IW-1:0]    idx_q;
    logic [IW:0]      nseg_q;
    logic [LEN_W-1:0] left_q, err_q;
    logic [RW-1:0]    rcnt_q;
    logic [CYC_W-1:0] total_q;
    logic             pass_q, stall, last, xfer, seg_end, pf_start, pf_valid;
    logic [W-1:0]     pf_data;

`ifdef DIL_STREAM_SEQ_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk) lfsr_q <= rst ? LFSR_SEED : lfsr_next(lfsr_q);
    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    assign entry    = tbl_q[idx_q];
    assign last     = {1'b0, idx_q} == nseg_q - (IW+1)'(1);
    assign xfer     = (m_valid && m_ready) || (s_valid && s_ready);
    assign seg_end  = xfer && left_q == LEN_W'(1);
    assign pf_start = state_q == S_SEG && entry.len != '0;

    dil_seq_prefetch #(.W(W), .LEN_W(LEN_W)) u_prefetch (
        .clk        (clk),
        .rst        (rst),
        .start_i    (pf_start),
        .base_i     (entry.base),
        .len_i      (entry.len),
        .pop_i      (xfer),
        .mem_addr_o (mem_addr),
        .mem_rdata_i(mem_rdata),
        .valid_o    (pf_valid),
        .data_o     (pf_data)
    );

    always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:           state_d = go ? S_DRST : S_IDLE;
            S_DRST:           state_d = rcnt_q == RW'(RST_CYCLES - 1) ? S_START : S_DRST;
            S_START:          state_d = nseg_q == '0 ? S_DONE : S_SEG;
            S_SEG:            state_d = entry.len == '0 ? (last ? S_DONE : S_SEG)
                                      : entry.dir == DIR_OUT ? S_UNLOAD : S_LOAD;
            S_LOAD, S_UNLOAD: state_d = seg_end ? (last ? S_DONE : S_SEG) : state_q;
            S_DONE:           state_d = S_IDLE;
            default:          state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != S_IDLE && state_q != S_DONE;
        done      = state_q == S_DONE;
        dut_rst   = state_q == S_DRST;
        dut_start = state_q == S_START;
        m_valid   = state_q == S_LOAD && pf_valid && !stall;
        s_ready   = state_q == S_UNLOAD && pf_valid && !stall;
        m_data    = state_q == S_LOAD && pf_valid ? pf_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            nseg_q  <= '0;
            left_q  <= '0;
            rcnt_q  <= '0;
            total_q <= '0;
            err_q   <= '0;
            pass_q  <= 1'b1;
            for (int i = 0; i < MAX_SEGS; i++) begin
                tbl_q[i] <= '0;
                cyc_q[i] <= '0;
            end
        end else begin
            if (seg_we && state_q == S_IDLE) tbl_q[seg_waddr] <= seg_wdata;
            if (go && state_q == S_IDLE) begin
                nseg_q <= num_segs > (IW+1)'(MAX_SEGS) ? (IW+1)'(MAX_SEGS) : num_segs;
                idx_q  <= '0;
                err_q  <= '0;
                pass_q <= 1'b1;
                for (int i = 0; i < MAX_SEGS; i++) cyc_q[i] <= '0;
            end
            rcnt_q <= state_q == S_DRST ? rcnt_q + RW'(1) : '0;
            if (state_q == S_START) total_q <= '0;
            if (state_q inside {S_SEG, S_LOAD, S_UNLOAD}) begin
                total_q      <= total_q + CYC_W'(1);
                cyc_q[idx_q] <= state_q == S_SEG ? CYC_W'(1) : cyc_q[idx_q] + CYC_W'(1);
            end
            if (state_q == S_SEG) left_q <= entry.len;
            if (xfer) left_q <= left_q - LEN_W'(1);
            if ((state_q == S_SEG && entry.len == '0) || seg_end) idx_q <= idx_q + IW'(1);
            // Unloaded words are checked against the prefetched expected word.
            if (s_valid && s_ready && s_data != pf_data) begin
                err_q  <= &err_q ? err_q : err_q + LEN_W'(1);
                pass_q <= 1'b0;
            end
        end
    end

    assign cyc_rdata = cyc_q[cyc_raddr];
    assign total_cyc = total_q;
    assign err_cnt   = err_q;
    assign pass      = pass_q;
endmodule

// File: tb/tb_dil_stream_sequencer.sv
// tb_dil_stream_sequencer: randomized bench with a timeline model of segment transfers.
module tb_dil_stream_sequencer;
    localparam int W = 64, LW = 12, NS = 16, CW = 32, RC = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic          seg_we = 1'b0, go = 1'b0, m_ready = 1'b0, s_valid = 1'b0;
    logic [3:0]    seg_waddr = '0, cyc_raddr = '0;
    logic [2*LW:0] seg_wdata = '0;
    logic [4:0]    num_segs = '0;
    logic [LW-1:0] mem_addr, err_cnt;
    logic [W-1:0]  mem_rdata, m_data, s_data = '0;
    logic          dut_rst, dut_start, m_valid, s_ready, busy, done, pass;
    logic [CW-1:0] cyc_rdata, total_cyc;

    logic [W-1:0]  ram [4096];
    logic [2*LW:0] tbl [NS];
    bit            mr [4096];
    bit            sv [4096];
    int            n_tests = 0, n_fail = 0, corrupt_pct = 0, corrupt_idx = -1;

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= ram[mem_addr];

    dil_stream_sequencer dut (
        .clk(clk), .rst(rst), .seg_we(seg_we), .seg_waddr(seg_waddr), .seg_wdata(seg_wdata),
        .num_segs(num_segs), .go(go), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dut_rst(dut_rst), .dut_start(dut_start), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .busy(busy),
        .done(done), .pass(pass), .err_cnt(err_cnt), .cyc_raddr(cyc_raddr),
        .cyc_rdata(cyc_rdata), .total_cyc(total_cyc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_seg(input int idx, input bit dir, input int len, input int base);
        @(negedge clk);
        seg_we    = 1'b1;
        seg_waddr = idx[3:0];
        seg_wdata = {dir, len[LW-1:0], base[LW-1:0]};
        tbl[idx]  = seg_wdata;
        @(negedge clk);
        seg_we = 1'b0;
    endtask

    task automatic fill_ready(input int mode);
        for (int k = 0; k < 4096; k++) begin
            mr[k] = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : ($urandom_range(99) < 70);
            sv[k] = mode == 2 ? ($urandom_range(99) < 70) : 1'b1;
        end
    endtask

    task automatic read_cyc(input int s, output logic [CW-1:0] v);
        cyc_raddr = s[3:0];
        #1;
        v = cyc_rdata;
    endtask

    // Cycle k = 0 is the first cycle after go: k 0..RC-1 reset, k RC start, first segment at RC+1.
    // A segment occupies one setup cycle, then transfers on every cycle its handshake input is high.
    task automatic run(input int n, input int abort_after, input string nm);
        logic [W-1:0]  lq[$], sq[$];
        logic [W-1:0]  prev_data = '0;
        logic [CW-1:0] cv;
        int            exp_cyc[NS];
        int            exp_err = 0, exp_total = 0, seg_k = RC + 1, ui = 0;
        int            got_done = -1, starts = 0, rsts = 0, nx = 0;
        bit            prev_hold = 1'b0;
        for (int s = 0; s < n; s++) begin
            bit d    = tbl[s][2*LW];
            int len  = int'(tbl[s][2*LW-1:LW]);
            int base = int'(tbl[s][LW-1:0]);
            int j    = seg_k;
            int got  = 0;
            for (int i = 0; i < len; i++) begin
                logic [W-1:0] w = ram[(base + i) % 4096];
                if (d) begin
                    bit c = (ui == corrupt_idx) || ($urandom_range(99) < corrupt_pct);
                    sq.push_back(c ? ~w : w);
                    exp_err += int'(c);
                    ui++;
                end else lq.push_back(w);
            end
            while (got < len && j < 4000) begin
                j++;
                if (d ? sv[j] : mr[j]) got++;
            end
            exp_cyc[s] = j - seg_k + 1;
            exp_total += exp_cyc[s];
            seg_k = j + 1;
        end
        @(negedge clk);
        num_segs = n[4:0];
        go = 1'b1;
        for (int k = 0; k < 3000 && got_done < 0; k++) begin
            @(negedge clk);
            go        = k == 3;
            num_segs  = k == 3 ? 5'($urandom_range(16)) : num_segs;
            seg_we    = k == 2;
            seg_waddr = '0;
            seg_wdata = ~tbl[0];
            m_ready   = mr[k];
            s_valid   = sv[k];
            s_data    = sq.size() != 0 ? sq[0] : {$urandom, $urandom};
            #1;
            starts += int'(dut_start);
            rsts   += int'(dut_rst);
            if (lq.size() == 0) chk({nm, "/no_mvalid"}, m_valid, 1'b0);
            if (sq.size() == 0) chk({nm, "/no_sready"}, s_ready, 1'b0);
`ifndef DIL_STREAM_SEQ_STALL_EN
            if (prev_hold) begin
                chk({nm, "/hold_valid"}, m_valid, 1'b1);
                chk({nm, "/hold_data"}, m_data, prev_data);
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
`endif
            if (m_valid && m_ready && lq.size() != 0) begin
                chk({nm, "/m_data"}, m_data, lq.pop_front());
                nx++;
            end
            if (s_valid && s_ready && sq.size() != 0) void'(sq.pop_front());
            if (done) got_done = k;
            if (abort_after > 0 && nx == abort_after) begin
                rst = 1'b1;
                @(negedge clk);
                rst     = 1'b0;
                m_ready = 1'b0;
                s_valid = 1'b0;
                #1;
                chk({nm, "/m_valid"}, m_valid, 1'b0);
                chk({nm, "/busy"}, busy, 1'b0);
                chk({nm, "/dut_rst"}, dut_rst, 1'b0);
                chk({nm, "/pass"}, pass, 1'b1);
                chk({nm, "/total"}, total_cyc, '0);
                read_cyc(0, cv);
                chk({nm, "/cyc0"}, cv, '0);
                for (int i = 0; i < NS; i++) tbl[i] = '0;
                return;
            end
        end
        chk({nm, "/done_seen"}, got_done >= 0, 1'b1);
        chk({nm, "/busy_at_done"}, busy, 1'b0);
        chk({nm, "/pass"}, pass, exp_err == 0);
        chk({nm, "/err_cnt"}, err_cnt, exp_err);
        chk({nm, "/starts"}, starts, 1);
        chk({nm, "/rst_cycles"}, rsts, RC);
        chk({nm, "/load_left"}, lq.size(), 0);
        chk({nm, "/unload_left"}, sq.size(), 0);
`ifndef DIL_STREAM_SEQ_STALL_EN
        chk({nm, "/done_cycle"}, got_done, seg_k);
        chk({nm, "/total"}, total_cyc, exp_total);
        for (int s = 0; s < n; s++) begin
            read_cyc(s, cv);
            chk({nm, "/cyc"}, cv, exp_cyc[s]);
        end
`else
        chk({nm, "/total_ge"}, total_cyc >= exp_total, 1'b1);
`endif
        @(negedge clk);
        m_ready = 1'b0;
        s_valid = 1'b0;
        #1;
        chk({nm, "/done_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [CW-1:0] cv;
        for (int i = 0; i < 4096; i++) ram[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) ram[i] = W'(i + 1);
        for (int i = 0; i < NS; i++) tbl[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst/busy", busy, 1'b0);
        chk("rst/done", done, 1'b0);
        chk("rst/pass", pass, 1'b1);
        chk("rst/err", err_cnt, '0);
        chk("rst/total", total_cyc, '0);
        chk("rst/m_valid", m_valid, 1'b0);
        chk("rst/s_ready", s_ready, 1'b0);
        chk("rst/dut_rst", dut_rst, 1'b0);
        chk("rst/dut_start", dut_start, 1'b0);
        chk("rst/mem_addr", mem_addr, '0);
        chk("rst/m_data", m_data, '0);
        read_cyc(0, cv);
        chk("rst/cyc0", cv, '0);

        fill_ready(0);
        write_seg(0, 1'b0, 4, 0);
        run(1, 0, "basic");
`ifndef DIL_STREAM_SEQ_STALL_EN
        read_cyc(0, cv);
        chk("basic/cyc0_is_5", cv, 5);
`endif
        run(1, 0, "rerun");

        write_seg(0, 1'b0, 4, 0);
        write_seg(1, 1'b1, 3, 16);
        corrupt_idx = 1;
        run(2, 0, "ld_unld");
        chk("ld_unld/err_is_1", err_cnt, 1);
        chk("ld_unld/pass_low", pass, 1'b0);
        corrupt_idx = -1;

        fill_ready(1);
        write_seg(0, 1'b0, 8, 32);
        run(1, 0, "bp");
`ifndef DIL_STREAM_SEQ_STALL_EN
        read_cyc(0, cv);
        chk("bp/cyc0_is_16", cv, 16);
`endif

        fill_ready(0);
        run(0, 0, "nsegs0");
        write_seg(0, 1'b0, 0, 5);
        run(1, 0, "len0");
`ifndef DIL_STREAM_SEQ_STALL_EN
        read_cyc(0, cv);
        chk("len0/cyc0_is_1", cv, 1);
`endif

        write_seg(0, 1'b0, 8, 40);
        run(1, 2, "abort");
        run(0, 0, "post_abort0");
        run(1, 0, "post_abort_tbl");

        corrupt_pct = 20;
        for (int r = 0; r < 10; r++) begin
            int n = $urandom_range(1, 5);
            fill_ready(2);
            for (int s = 0; s < n; s++) write_seg(s, 1'($urandom_range(1)), $urandom_range(0, 6), $urandom_range(0, 300));
            run(n, 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
